control_unit_pipelined: RTL
===========================

# control_unit_pipelined

Parametrised decode-and-control stage for the pipelined RV32I core, sitting between the IF/ID register and the EX stage. Decodes the opcode into the datapath control bundle and registers it into the ID/EX boundary with stall/flush bubble insertion. A halt state machine drains the pipeline on ECALL/EBREAK/FENCE or an illegal opcode, then freezes fetch. A saturating counter records accepted instructions.

## Interface
- OPC_W, 7: opcode input width; 7 = full opcode with bits[1:0] required to be 2'b11; 5 = pre-stripped opcode[6:2].
- DRAIN_CYCLES, 3: cycles spent in DRAIN before HALTED; legal range 1..15.
- CNT_W, 16: width of the accepted-instruction counter.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- opcode  in  OPC_W  instruction opcode field.
- stall  in  1  hazard stall; insert bubble into EX.
- flush  in  1  branch/jump flush; insert bubble into EX.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch, ex_jal, ex_jalr, ex_auipc, ex_halt  out  1 each  registered control bundle.
- ex_alu_op  out  2  registered ALU op class.
- fetch_hold  out  1  freeze PC/IF; high whenever state != RUN.
- halted  out  1  high in HALTED.
- illegal  out  1  sticky; set when an illegal opcode is accepted.
- inst_count  out  CNT_W  accepted instructions, saturating.

## Operation
- Decode key k = opcode[6:2] (OPC_W=7) or opcode (OPC_W=5). With OPC_W=7 and opcode[1:0] != 2'b11 -> illegal.
- R 01100: reg_write, alu_op=10. I-ALU 00100: reg_write, alu_src, alu_op=10. Load 00000: mem_read, mem_to_reg, alu_src, reg_write, alu_op=00. Store 01000: mem_write, alu_src, alu_op=00. Branch 11000: branch, alu_op=01. AUIPC 00101: auipc, reg_write, alu_op=00 (branch=0). LUI 01101: reg_write, alu_src, alu_op=11. JAL 11011: jal, reg_write. JALR 11001: jalr, alu_src, reg_write. SYSTEM 11100 and FENCE 00011: halt, all other controls 0. Any other key: illegal, treated as halt.
- Accept = id_valid & ~stall & ~flush & state==RUN.
- On accept: ex_* <= decoded bundle, ex_valid <= 1, inst_count += 1 (holds at 2^CNT_W-1).
- Otherwise: bubble; all ex_* <= 0 including ex_valid.
- State machine: RUN -> DRAIN when a halt-class or illegal instruction is accepted (that instruction goes to EX with ex_halt=1); drain counter loads DRAIN_CYCLES. DRAIN: counter decrements each cycle; when it reaches 0 -> HALTED. HALTED: terminal until rst_n low.
- In DRAIN and HALTED nothing is accepted; EX receives bubbles; inst_count frozen.
- illegal sets on acceptance of an illegal opcode; cleared only by reset.

## Timing
- Reset (async assert, any cycle incl. mid-DRAIN): state=RUN, drain counter=0, all ex_* =0, fetch_hold=0, halted=0, illegal=0, inst_count=0.
- Decode-to-EX latency: 1 cycle (bundle visible the cycle after accept).
- fetch_hold and halted are registered from state; fetch_hold rises the cycle after the halt instruction is accepted; halted rises exactly DRAIN_CYCLES cycles after fetch_hold.
- stall and flush together: bubble; flush priority irrelevant since both squash. A halt opcode coinciding with stall or flush is not accepted; no state change.
- id_valid=0: bubble, no count, no state change.
- Counter saturation: at all-ones, further accepts leave it unchanged.

## Test plan
- Reset, then R opcode 0110011 with id_valid=1 -> next cycle ex_valid=1, ex_reg_write=1, ex_alu_op=10, others 0; inst_count=1.
- Load then Store back-to-back -> cycle1 mem_read=mem_to_reg=alu_src=reg_write=1; cycle2 mem_write=alu_src=1, reg_write=0; inst_count=2.
- Branch opcode with stall=1, then stall=0 -> first EX cycle all 0/ex_valid=0, second ex_branch=1, ex_alu_op=01; inst_count=1.
- ECALL 1110011, DRAIN_CYCLES=3, id_valid held high with R opcodes after -> ex_halt=1 one cycle, fetch_hold=1 next cycle, halted=1 three cycles later, inst_count frozen at 1.
- OPC_W=7, opcode 0110010 -> illegal=1, ex_halt=1, DRAIN entered; rst_n pulse low mid-DRAIN -> all outputs 0, state RUN.
- CNT_W=4, 17 accepted ADDI (0010011) -> inst_count saturates at 15.

Source files
------------

// File: rtl/control_unit_pipelined.sv
// control_unit_pipelined
//   ID-stage decode and control for the pipelined RV32I core. The opcode is
//   decoded into the datapath control bundle, which is registered into the
//   ID/EX boundary. Stalls and flushes insert bubbles. A halt state machine
//   drains the pipeline after ECALL/EBREAK/FENCE or an illegal opcode, then
//   freezes fetch. A saturating counter records accepted instructions.
//
// Parameters
//   OPC_W        7 = full opcode (bits[1:0] must be 2'b11), 5 = opcode[6:2]
//   DRAIN_CYCLES cycles spent draining before HALTED (1..15)
//   CNT_W        width of the accepted-instruction counter
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   id_valid, opcode     instruction presented by the IF/ID register
//   stall, flush         hazard stall / control flush; both squash into a bubble
//   ex_*                 registered control bundle for EX
//   fetch_hold           freeze PC/IF whenever not running
//   halted               pipeline fully drained and stopped
//   illegal              sticky illegal-opcode flag
//   inst_count           accepted instructions, saturating
module control_unit_pipelined #(
  parameter int OPC_W        = 7,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [OPC_W-1:0] opcode,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_alu_src,
  output logic             ex_branch,
  output logic             ex_jal,
  output logic             ex_jalr,
  output logic             ex_auipc,
  output logic             ex_halt,
  output logic [1:0]       ex_alu_op,
  output logic             fetch_hold,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] inst_count
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       auipc;
    logic       halt;
    logic [1:0] alu_op;
  } ctrl_t;

  state_e           state_q;
  logic [3:0]       drain_cnt_q;
  ctrl_t            ex_q;
  logic             ex_valid_q;
  logic             fetch_hold_q;
  logic             halted_q;
  logic             illegal_q;
  logic [CNT_W-1:0] inst_count_q;
  logic [CNT_W-1:0] inst_count_d;

  logic [4:0] key;
  logic       fmt_ok;
  ctrl_t      dec;
  logic       dec_illegal;
  logic       accept;

  // Decode key extraction depends on whether the low opcode bits are present.
  generate
    if (OPC_W == 7) begin : g_full_opc
      assign key    = opcode[6:2];
      assign fmt_ok = (opcode[1:0] == 2'b11);
    end else begin : g_stripped_opc
      assign key    = opcode[4:0];
      assign fmt_ok = 1'b1;
    end
  endgenerate

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    unique case (key)
      5'b01100: begin dec.reg_write = 1'b1; dec.alu_op = 2'b10; end
      5'b00100: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 2'b10; end
      5'b00000: begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
      end
      5'b01000: begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; end
      5'b11000: begin dec.branch = 1'b1; dec.alu_op = 2'b01; end
      5'b00101: begin dec.auipc = 1'b1; dec.reg_write = 1'b1; end
      5'b01101: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 2'b11; end
      5'b11011: begin dec.jal = 1'b1; dec.reg_write = 1'b1; end
      5'b11001: begin dec.jalr = 1'b1; dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
      5'b11100, 5'b00011: dec.halt = 1'b1;
      default: begin dec.halt = 1'b1; dec_illegal = 1'b1; end
    endcase
    // A malformed full opcode overrides whatever the key decoded to.
    if (!fmt_ok) begin
      dec         = '0;
      dec.halt    = 1'b1;
      dec_illegal = 1'b1;
    end
  end

  assign accept       = id_valid & ~stall & ~flush & (state_q == ST_RUN);
  assign inst_count_d = (&inst_count_q) ? inst_count_q : inst_count_q + CNT_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      drain_cnt_q  <= '0;
      ex_q         <= '0;
      ex_valid_q   <= 1'b0;
      fetch_hold_q <= 1'b0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
      inst_count_q <= '0;
    end else begin
      if (accept) begin
        ex_q         <= dec;
        ex_valid_q   <= 1'b1;
        inst_count_q <= inst_count_d;
        if (dec_illegal) illegal_q <= 1'b1;
      end else begin
        ex_q       <= '0;
        ex_valid_q <= 1'b0;
      end

      unique case (state_q)
        ST_RUN: begin
          if (accept && dec.halt) begin
            state_q      <= ST_DRAIN;
            drain_cnt_q  <= 4'(DRAIN_CYCLES);
            fetch_hold_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // The decrement that reaches zero is also the step into HALTED.
          if (drain_cnt_q <= 4'd1) begin
            state_q     <= ST_HALTED;
            drain_cnt_q <= '0;
            halted_q    <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q - 4'd1;
          end
        end
        default: state_q <= ST_HALTED;
      endcase
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_branch     = ex_q.branch;
  assign ex_jal        = ex_q.jal;
  assign ex_jalr       = ex_q.jalr;
  assign ex_auipc      = ex_q.auipc;
  assign ex_halt       = ex_q.halt;
  assign ex_alu_op     = ex_q.alu_op;
  assign fetch_hold    = fetch_hold_q;
  assign halted        = halted_q;
  assign illegal       = illegal_q;
  assign inst_count    = inst_count_q;

endmodule
